// File: rtl/alu_sequencer_if.sv
// Bundle between the ALU sequencer, instruction memory and the ALU.
// Fetch handshake: imem_req stays high until a cycle with imem_valid=1, which completes the fetch; valid is ignored while req is low.
interface alu_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic [5:0]  alu_instr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_reg8;
    logic [15:0] alu_value;
    logic        alu_highlow;
    logic        alu_f1;
    logic        alu_f2;
    logic [31:0] alu_c;
    logic        alu_f3;
    logic        alu_addrch;
    logic [31:0] alu_naddr;
    logic [2:0]  dbg_state;

    modport master (
        output imem_req, imem_addr, alu_instr, alu_a, alu_b, alu_reg8,
               alu_value, alu_highlow, alu_f1, alu_f2, dbg_state,
        input  imem_valid, imem_data, alu_c, alu_f3, alu_addrch, alu_naddr
    );

    modport slave (
        input  imem_req, imem_addr, alu_instr, alu_a, alu_b, alu_reg8,
               alu_value, alu_highlow, alu_f1, alu_f2, dbg_state,
        output imem_valid, imem_data, alu_c, alu_f3, alu_addrch, alu_naddr
    );
endinterface

// File: rtl/alu_sequencer.sv
// Control-path sequencer: fetches, decodes and retires one instruction every
// four or more cycles, owning the register file, flags and program counter.
module alu_sequencer #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          NREGS    = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    alu_sequencer_if.master bus,
    output logic [31:0]     pc,
    output logic            halted
);
    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    localparam logic [5:0] OP_IDLE = 6'd16;
    localparam logic [5:0] OP_HALT = 6'd63;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        imem_req_q, imem_req_d;
    logic [5:0]  alu_instr_q, alu_instr_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [15:0] alu_value_q, alu_value_d;
    logic        alu_highlow_q, alu_highlow_d;
    logic        f1_q, f1_d;
    logic        f2_q, f2_d;
    logic [31:0] regs_q [NREGS];
    logic [31:0] regs_d [NREGS];

    logic [5:0]  op;
    logic [3:0]  rd, ra, rb;
    logic        fetch_done;
    logic        unused_ir_bit;

    assign op            = ir_q[31:26];
    assign rd            = ir_q[25:22];
    assign ra            = ir_q[21:18];
    assign rb            = ir_q[17:14];
    assign unused_ir_bit = ir_q[16];
    assign fetch_done    = imem_req_q && bus.imem_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (fetch_done) state_d = S_DECODE;
            S_DECODE:    state_d = S_EXECUTE;
            S_EXECUTE:   state_d = S_WRITEBACK;
            S_WRITEBACK: state_d = (op == OP_HALT) ? S_HALT : S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_FETCH;
        endcase
    end

    // Drive lines change only on the DECODE edge and return to idle at the end of WRITEBACK.
    always_comb begin
        pc_d          = pc_q;
        ir_d          = ir_q;
        imem_req_d    = (state_d == S_FETCH);
        alu_instr_d   = alu_instr_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_value_d   = alu_value_q;
        alu_highlow_d = alu_highlow_q;
        f1_d          = f1_q;
        f2_d          = f2_q;
        regs_d        = regs_q;
        case (state_q)
            S_FETCH: begin
                if (fetch_done) ir_d = bus.imem_data;
            end
            S_DECODE: begin
                alu_instr_d   = op;
                alu_a_d       = regs_q[ra];
                alu_b_d       = regs_q[rb];
                alu_value_d   = ir_q[15:0];
                alu_highlow_d = ir_q[17];
            end
            S_WRITEBACK: begin
                alu_instr_d = OP_IDLE;
                pc_d        = pc_q + 32'd1;
                if (op <= 6'd5) begin
                    regs_d[rd] = bus.alu_c;
                end else if (op >= 6'd8 && op <= 6'd13) begin
                    f2_d = f1_q;
                    f1_d = bus.alu_f3;
                end else if (op == 6'd14 || op == 6'd15) begin
                    if (bus.alu_addrch) pc_d = bus.alu_naddr;
                end else if (op == OP_HALT) begin
                    pc_d = pc_q;
                end
                regs_d[0] = 32'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= PC_RESET;
            ir_q          <= 32'd0;
            imem_req_q    <= 1'b0;
            alu_instr_q   <= OP_IDLE;
            alu_a_q       <= 32'd0;
            alu_b_q       <= 32'd0;
            alu_value_q   <= 16'd0;
            alu_highlow_q <= 1'b0;
            f1_q          <= 1'b0;
            f2_q          <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            imem_req_q    <= imem_req_d;
            alu_instr_q   <= alu_instr_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_value_q   <= alu_value_d;
            alu_highlow_q <= alu_highlow_d;
            f1_q          <= f1_d;
            f2_q          <= f2_d;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.alu_instr   = alu_instr_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_reg8    = regs_q[8];
    assign bus.alu_value   = alu_value_q;
    assign bus.alu_highlow = alu_highlow_q;
    assign bus.alu_f1      = f1_q;
    assign bus.alu_f2      = f2_q;
    assign bus.dbg_state   = state_q;
    assign pc              = pc_q;
    assign halted          = (state_q == S_HALT);
endmodule
